// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard controller for the 5-stage bypassing CPU.
// Tracks the destinations of instructions in EX and MEM. From these it
// produces the bypass selects, load-use stalls, taken-branch flushes and the
// ecall halt/drain/restart sequence. It owns no datapath.
//
// Ports
//   CLK, RST                   clock (rising edge), async active-high reset
//   ID_R1/ID_R2, R1_Used/R2_Used  source operands of the ID instruction
//   ID_RD, ID_RegWrite         destination of the ID instruction
//   ID_MemRead, ID_Halt        ID instruction is a load / a halting ecall
//   EX_Taken                   branch or jalr in EX resolved taken
//   GO                         restart pulse, only honoured while halted
//   PC_Stall, IFID_Stall       hold PC / hold the IF/ID register
//   IFID_Flush, IDEX_Flush     clear IF/ID / inject a bubble into ID/EX
//   FWD_A, FWD_B               registered EX operand source
//                              (00 regfile, 01 EX/MEM, 10 MEM/WB)
//   Halted                     pipeline drained and stopped
//   STALL_CNT, FLUSH_CNT       wrapping load-use stall / flush statistics
module hazard_ctrl #(
  parameter int CNT_W = 16,
  parameter int DRAIN = 3
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [4:0]       ID_R1,
  input  logic [4:0]       ID_R2,
  input  logic             R1_Used,
  input  logic             R2_Used,
  input  logic [4:0]       ID_RD,
  input  logic             ID_RegWrite,
  input  logic             ID_MemRead,
  input  logic             ID_Halt,
  input  logic             EX_Taken,
  input  logic             GO,
  output logic             PC_Stall,
  output logic             IFID_Stall,
  output logic             IFID_Flush,
  output logic             IDEX_Flush,
  output logic [1:0]       FWD_A,
  output logic [1:0]       FWD_B,
  output logic             Halted,
  output logic [CNT_W-1:0] STALL_CNT,
  output logic [CNT_W-1:0] FLUSH_CNT
);

  localparam int CW = $clog2(DRAIN + 1);

  typedef enum logic [1:0] {RUN, DRAINING, HALTED} state_t;

  typedef struct packed {
    logic [4:0] rd;
    logic       wr;
    logic       ld;
  } slot_t;

  // Only the load flag of the EX slot matters (load-use). The WB-stage
  // producer is never tracked: the regfile writes before the ID read, so a
  // WB-stage destination never needs a bypass.
  typedef struct packed {
    logic [4:0] rd;
    logic       wr;
  } mslot_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  slot_t          ex_q, ex_d;
  mslot_t         mem_q;
  logic [1:0]     fwd_a_q, fwd_b_q, fwd_a_d, fwd_b_d;
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;
  logic           lu, stall_inc, flush_inc;

  // Load-use: the producer in EX is a load whose data is not ready yet.
  assign lu = ex_q.ld && ex_q.wr &&
              ((R1_Used && ex_q.rd == ID_R1) || (R2_Used && ex_q.rd == ID_R2));

  // Bypass selects for the ID instruction; the EX slot is younger and wins.
  always_comb begin
    fwd_a_d = 2'b00;
    fwd_b_d = 2'b00;
    if (R1_Used && ex_q.wr && ex_q.rd == ID_R1)        fwd_a_d = 2'b01;
    else if (R1_Used && mem_q.wr && mem_q.rd == ID_R1) fwd_a_d = 2'b10;
    if (R2_Used && ex_q.wr && ex_q.rd == ID_R2)        fwd_b_d = 2'b01;
    else if (R2_Used && mem_q.wr && mem_q.rd == ID_R2) fwd_b_d = 2'b10;
  end

  // Slot entering EX: the ID instruction, or a bubble. A write to x0 is
  // never recorded, so x0 is never bypassed and never causes a stall.
  always_comb begin
    ex_d = '0;
    if (!IDEX_Flush) begin
      ex_d.rd = ID_RD;
      ex_d.wr = ID_RegWrite && (ID_RD != 5'd0);
      ex_d.ld = ID_MemRead;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    PC_Stall   = 1'b0;
    IFID_Stall = 1'b0;
    IFID_Flush = 1'b0;
    IDEX_Flush = 1'b0;
    Halted     = 1'b0;
    stall_inc  = 1'b0;
    flush_inc  = 1'b0;
    case (state_q)
      RUN: begin
        if (EX_Taken) begin
          // The redirect squashes the ID instruction (stall or ecall alike).
          IFID_Flush = 1'b1;
          IDEX_Flush = 1'b1;
          flush_inc  = 1'b1;
        end else if (lu) begin
          // A stalled ecall is simply retried on the next cycle.
          PC_Stall   = 1'b1;
          IFID_Stall = 1'b1;
          IDEX_Flush = 1'b1;
          stall_inc  = 1'b1;
        end else if (ID_Halt) begin
          state_d = DRAINING;
          cnt_d   = '0;
        end
      end
      DRAINING: begin
        // Older instructions are still resolving; a late EX_Taken is ignored.
        PC_Stall   = 1'b1;
        IFID_Stall = 1'b1;
        IDEX_Flush = 1'b1;
        cnt_d      = cnt_q + CW'(1);
        if (cnt_q == CW'(DRAIN - 1)) state_d = HALTED;
      end
      HALTED: begin
        Halted     = 1'b1;
        PC_Stall   = 1'b1;
        IFID_Stall = 1'b1;
        IDEX_Flush = 1'b1;
        if (GO) begin
          IFID_Flush = 1'b1;
          state_d    = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= RUN;
      cnt_q       <= '0;
      ex_q        <= '0;
      mem_q       <= '0;
      fwd_a_q     <= 2'b00;
      fwd_b_q     <= 2'b00;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      // Scoreboard advances with the pipeline and freezes once halted.
      if (state_q != HALTED) begin
        ex_q     <= ex_d;
        mem_q.rd <= ex_q.rd;
        mem_q.wr <= ex_q.wr;
      end
      fwd_a_q <= IDEX_Flush ? 2'b00 : fwd_a_d;
      fwd_b_q <= IDEX_Flush ? 2'b00 : fwd_b_d;
      if (stall_inc) stall_cnt_q <= stall_cnt_q + 1'b1;
      if (flush_inc) flush_cnt_q <= flush_cnt_q + 1'b1;
    end
  end

  assign FWD_A     = fwd_a_q;
  assign FWD_B     = fwd_b_q;
  assign STALL_CNT = stall_cnt_q;
  assign FLUSH_CNT = flush_cnt_q;

endmodule
